// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Brief    : Shared types and constants for the round-robin one-hot arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Default number of requesters sharing the resource
    localparam int DEF_NUM_REQ  = 16;

    // Default hold limit in grant cycles; 0 disables the forced revoke
    localparam int DEF_MAX_HOLD = 255;

    // Arbiter control states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a binary index able to address n requesters (at least 1 bit)
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module   : bin2onehot_dec
//  Brief    : Binary index to one-hot decoder with an output enable. When
//             disabled the output vector is all zero.
//  Revision : 1.0 - initial release
// ============================================================================
module bin2onehot_dec #(
    parameter int IDX_W   = 4,
    parameter int NUM_REQ = 16
) (
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    // Each output bit is a compare of the index against its own position
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_dec
        assign onehot[i] = en && (idx == IDX_W'(i));
    end

endmodule
`default_nettype wire

// File: rtl/arb_rr_onehot.sv
`default_nettype none
// ============================================================================
//  Module   : arb_rr_onehot
//  Brief    : Round-robin arbiter with held grants, owner release, implicit
//             release on request drop and an optional hold timeout. Grant is
//             reported as a binary index and as a one-hot select vector.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_rr_onehot
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int IDX_W    = idx_width(NUM_REQ),
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rel,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic               timeout_pulse,
    output logic               busy
);

    // Last hold count value of a grant; only meaningful when the timeout is on
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  rr_ptr;

    logic              any_req;
    logic [IDX_W-1:0]  win_idx;
    int                cand;

    logic              rel_exit;
    logic              hold_exp;
    logic [IDX_W-1:0]  next_ptr;

    // Rotating-priority search: first set request at or after rr_ptr, wrapping
    // modulo NUM_REQ (not modulo 2^IDX_W)
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    // Grant exit causes and the pointer value that follows the current owner
    always_comb begin
        rel_exit = rel || !req[gnt_idx];
        hold_exp = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        next_ptr = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
    end

    // Arbiter FSM; all grant outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gnt_valid     <= 1'b0;
            gnt_idx       <= '0;
            timeout_pulse <= 1'b0;
            hold_cnt      <= '0;
            rr_ptr        <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= GRANT;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= win_idx;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (rel_exit || hold_exp) begin
                        state         <= IDLE;
                        gnt_valid     <= 1'b0;
                        gnt_idx       <= '0;
                        hold_cnt      <= '0;
                        rr_ptr        <= next_ptr;
                        // A release in the same cycle as expiry wins over the timeout
                        timeout_pulse <= !rel_exit;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = gnt_valid;

    bin2onehot_dec #(
        .IDX_W   (IDX_W),
        .NUM_REQ (NUM_REQ)
    ) u_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid),
        .onehot (gnt_onehot)
    );

endmodule
`default_nettype wire

// File: tb/tb_arb_rr_onehot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_rr_onehot
//  Brief    : Self-checking bench for arb_rr_onehot. One instance uses the
//             default hold limit, a second one uses a hold limit of 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arb_rr_onehot;

    typedef struct {
        int          tgt;     // 0: default instance, 1: MAX_HOLD=4 instance
        logic        rst;
        logic [15:0] req;
        logic        rel;
        logic        exp_v;
        logic [3:0]  exp_idx;
        logic        exp_to;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rel_a = 1'b0;
    logic [15:0] req_a = '0;
    logic        rst_b = 1'b1, rel_b = 1'b0;
    logic [15:0] req_b = '0;

    logic        v_a, to_a, busy_a, v_b, to_b, busy_b;
    logic [3:0]  idx_a, idx_b;
    logic [15:0] oh_a, oh_b;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    arb_rr_onehot #(.NUM_REQ(16), .IDX_W(4), .MAX_HOLD(255), .HOLD_W(8)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .rel(rel_a),
        .gnt_valid(v_a), .gnt_idx(idx_a), .gnt_onehot(oh_a),
        .timeout_pulse(to_a), .busy(busy_a)
    );

    arb_rr_onehot #(.NUM_REQ(16), .IDX_W(4), .MAX_HOLD(4), .HOLD_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .rel(rel_b),
        .gnt_valid(v_b), .gnt_idx(idx_b), .gnt_onehot(oh_b),
        .timeout_pulse(to_b), .busy(busy_b)
    );

    task automatic add(input int tgt, input logic rst, input logic [15:0] req, input logic rel,
                       input logic v, input logic [3:0] idx, input logic to, input string name);
        vec_t r;
        r.tgt = tgt; r.rst = rst; r.req = req; r.rel = rel;
        r.exp_v = v; r.exp_idx = idx; r.exp_to = to; r.name = name;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, let one edge pass, then compare against the queued expectation
    task automatic apply(input vec_t v);
        vec_t e;
        logic [15:0] exp_oh;
        if (v.tgt == 0) begin
            rst_a = v.rst; req_a = v.req; rel_a = v.rel;
        end else begin
            rst_b = v.rst; req_b = v.req; rel_b = v.rel;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        exp_oh = e.exp_v ? (16'h0001 << e.exp_idx) : 16'h0000;
        if (e.tgt == 0) begin
            check({e.name, ".valid"},   {15'd0, v_a},    {15'd0, e.exp_v});
            check({e.name, ".idx"},     {12'd0, idx_a},  {12'd0, e.exp_v ? e.exp_idx : 4'd0});
            check({e.name, ".onehot"},  oh_a,            exp_oh);
            check({e.name, ".timeout"}, {15'd0, to_a},   {15'd0, e.exp_to});
            check({e.name, ".busy"},    {15'd0, busy_a}, {15'd0, e.exp_v});
        end else begin
            check({e.name, ".valid"},   {15'd0, v_b},    {15'd0, e.exp_v});
            check({e.name, ".idx"},     {12'd0, idx_b},  {12'd0, e.exp_v ? e.exp_idx : 4'd0});
            check({e.name, ".onehot"},  oh_b,            exp_oh);
            check({e.name, ".timeout"}, {15'd0, to_b},   {15'd0, e.exp_to});
            check({e.name, ".busy"},    {15'd0, busy_b}, {15'd0, e.exp_v});
        end
    endtask

    initial begin
        // Reset, idle with no requests
        for (int i = 0; i < 3; i++) add(0, 1, 16'h0000, 0, 0, 0, 0, "reset");
        add(0, 0, 16'h0000, 0, 0, 0, 0, "idle_noreq");
        // Single requester, explicit release
        add(0, 0, 16'h0001, 0, 1, 0, 0, "single_gnt");
        for (int i = 0; i < 3; i++) add(0, 0, 16'h0001, 0, 1, 0, 0, "single_hold");
        add(0, 0, 16'h0001, 1, 0, 0, 0, "single_rel");
        add(0, 0, 16'h0000, 0, 0, 0, 0, "single_idle");
        // Wrap-around rotation from a fresh pointer
        add(0, 1, 16'h0000, 0, 0, 0, 0, "rr_reset");
        add(0, 0, 16'h8005, 0, 1, 0, 0, "rr_g0");
        add(0, 0, 16'h8005, 1, 0, 0, 0, "rr_gap0");
        add(0, 0, 16'h8005, 0, 1, 2, 0, "rr_g2");
        add(0, 0, 16'h8005, 1, 0, 0, 0, "rr_gap2");
        add(0, 0, 16'h8005, 0, 1, 15, 0, "rr_g15");
        add(0, 0, 16'h8005, 1, 0, 0, 0, "rr_gap15");
        add(0, 0, 16'h8005, 0, 1, 0, 0, "rr_g0_wrap");
        add(0, 0, 16'h8005, 1, 0, 0, 0, "rr_gap_wrap");
        add(0, 0, 16'h0000, 1, 0, 0, 0, "rel_in_idle");
        // Owner drops its request (pointer now 1)
        add(0, 0, 16'h0006, 0, 1, 1, 0, "drop_g1");
        add(0, 0, 16'h0006, 0, 1, 1, 0, "drop_hold");
        add(0, 0, 16'h0004, 0, 0, 0, 0, "drop_exit");
        add(0, 0, 16'h0004, 0, 1, 2, 0, "drop_g2");
        add(0, 0, 16'h0000, 0, 0, 0, 0, "drop_idle");
        // Reset in the middle of a grant on idx 9 (pointer now 3)
        add(0, 0, 16'h0200, 0, 1, 9, 0, "rstmid_g9");
        add(0, 0, 16'h0200, 0, 1, 9, 0, "rstmid_hold");
        add(0, 1, 16'h0200, 0, 0, 0, 0, "rstmid_rst");
        add(0, 0, 16'h0201, 0, 1, 0, 0, "rstmid_g0");

        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
        rst_a = 1'b0; req_a = '0; rel_a = 1'b0;

        // Hold timeout with MAX_HOLD=4, no release
        add(1, 1, 16'h0000, 0, 0, 0, 0, "to_reset");
        add(1, 0, 16'h0010, 0, 1, 4, 0, "to_g4");
        for (int i = 0; i < 3; i++) add(1, 0, 16'h0010, 0, 1, 4, 0, "to_hold");
        add(1, 0, 16'h0010, 0, 0, 0, 1, "to_pulse");
        add(1, 0, 16'h0010, 0, 1, 4, 0, "to_regrant");
        for (int i = 0; i < 3; i++) add(1, 0, 16'h0010, 0, 1, 4, 0, "to_hold2");
        // Release coinciding with expiry is a normal release
        add(1, 0, 16'h0010, 1, 0, 0, 0, "to_rel_wins");
        add(1, 0, 16'h0000, 0, 0, 0, 0, "to_idle");
        // Request dropped exactly at expiry is an implicit release
        add(1, 0, 16'h0010, 0, 1, 4, 0, "to_g4b");
        for (int i = 0; i < 3; i++) add(1, 0, 16'h0010, 0, 1, 4, 0, "to_hold3");
        add(1, 0, 16'h0000, 0, 0, 0, 0, "to_drop_wins");
        add(1, 0, 16'h0000, 0, 0, 0, 0, "to_idle2");

        foreach (tbl[i]) apply(tbl[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
